// File: rtl/xres_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module   : xres_reset_sequencer
// Brief    : Synchronises/debounces the XRES pad and releases hk, core, user
//            resets in order. Optional glitch counter: XRES_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xres_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SEQ_DELAY       = 8
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       xres_n,
    output logic       hk_resetb,
    output logic       core_resetb,
    output logic       user_resetb,
    output logic       seq_busy
`ifdef XRES_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [7:0] c_deb_last = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_seq_last = 8'(SEQ_DELAY - 1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_REL_HK   = 3'd2,
        ST_REL_CORE = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_xs;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_hk_nxt;
    logic                   w_core_nxt;
    logic                   w_user_nxt;
    logic                   w_busy_nxt;

    // Pad synchroniser: stage 0 captures the raw pad, later stages filter metastability
    generate
        for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync_stage
            if (g == 0) begin : g_first
                always_ff @(posedge clock or negedge resetb) begin
                    if (!resetb) r_sync[0] <= 1'b0;
                    else         r_sync[0] <= xres_n;
                end
            end else begin : g_rest
                always_ff @(posedge clock or negedge resetb) begin
                    if (!resetb) r_sync[g] <= 1'b0;
                    else         r_sync[g] <= r_sync[g-1];
                end
            end
        end
    endgenerate

    assign w_xs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state     <= ST_HOLD;
            r_cnt       <= 8'd0;
            hk_resetb   <= 1'b0;
            core_resetb <= 1'b0;
            user_resetb <= 1'b0;
            seq_busy    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            hk_resetb   <= w_hk_nxt;
            core_resetb <= w_core_nxt;
            user_resetb <= w_user_nxt;
            seq_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_xs) begin
            // Assertion always wins over any pending release step
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_cnt_nxt   = 8'd0;
                end
                ST_DEBOUNCE: begin
                    if (r_cnt == c_deb_last) begin
                        w_state_nxt = ST_REL_HK;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_REL_HK: begin
                    if (r_cnt == c_seq_last) begin
                        w_state_nxt = ST_REL_CORE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_REL_CORE: begin
                    if (r_cnt == c_seq_last) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = 8'd0;
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the transition edge
    always_comb begin
        w_hk_nxt   = (w_state_nxt == ST_REL_HK) || (w_state_nxt == ST_REL_CORE) ||
                     (w_state_nxt == ST_RUN);
        w_core_nxt = (w_state_nxt == ST_REL_CORE) || (w_state_nxt == ST_RUN);
        w_user_nxt = (w_state_nxt == ST_RUN);
        w_busy_nxt = (w_state_nxt != ST_RUN);
    end

`ifdef XRES_GLITCH_CNT_EN
    logic       w_glitch;
    logic [7:0] r_glitch_cnt;

    assign w_glitch = (r_state == ST_DEBOUNCE) && !w_xs;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb)                                r_glitch_cnt <= 8'd0;
        else if (w_glitch && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xres_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_xres_reset_sequencer
// Brief    : Directed bench for xres_reset_sequencer (defaults 2/16/8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xres_reset_sequencer;

    logic       clock = 1'b0;
    logic       resetb = 1'b1;
    logic       xres_n = 1'b1;
    logic       hk_resetb;
    logic       core_resetb;
    logic       user_resetb;
    logic       seq_busy;
`ifdef XRES_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_eval = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;
    logic user_seen = 1'b0;

    xres_reset_sequencer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .SEQ_DELAY      (8)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .xres_n     (xres_n),
        .hk_resetb  (hk_resetb),
        .core_resetb(core_resetb),
        .user_resetb(user_resetb),
        .seq_busy   (seq_busy)
`ifdef XRES_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_eval++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pattern packed as {hk, core, user, busy}
    task automatic chk_out(input string tag, input logic [3:0] exp);
        check(tag, {4'd0, hk_resetb, core_resetb, user_resetb, seq_busy}, {4'd0, exp});
    endtask

    // Advance n rising edges, then park on the following falling edge
    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            n_eval++;
            assert (!(core_resetb && !hk_resetb) && !(user_resetb && !core_resetb))
            else begin
                n_fail++;
                $error("FAIL order: observed hk=%0b core=%0b user=%0b expected ordered release",
                       hk_resetb, core_resetb, user_resetb);
            end
            if (user_resetb) user_seen = 1'b1;
        end
    end

    initial begin
        // Power-on reset, checked before any clock edge
        #3 resetb = 1'b0;
        #1 chk_out("por_async", 4'b0001);
`ifdef XRES_GLITCH_CNT_EN
        check("por_glitch_cnt", glitch_cnt, 8'd0);
`endif
        edges(2);
        chk_out("por_held", 4'b0001);
        mon_en = 1'b1;

        // Release with xres_n high: hk@18, core@26, user@34
        resetb = 1'b1;
        edges(18);
        chk_out("rel_e17", 4'b0001);
        edges(1);
        chk_out("rel_hk_e18", 4'b1001);
        edges(7);
        chk_out("rel_e25", 4'b1001);
        edges(1);
        chk_out("rel_core_e26", 4'b1101);
        edges(7);
        chk_out("rel_e33", 4'b1101);
        edges(1);
        chk_out("rel_user_e34", 4'b1110);

        // One-cycle pad pulse in RUN
        xres_n = 1'b0;
        edges(1);
        xres_n = 1'b1;
        chk_out("pulse_f0", 4'b1110);
        edges(1);
        chk_out("pulse_f1", 4'b1110);
        edges(1);
        chk_out("pulse_f2_low", 4'b0001);
        edges(16);
        chk_out("pulse_e17", 4'b0001);
        edges(1);
        chk_out("pulse_hk_e18", 4'b1001);
        edges(8);
        chk_out("pulse_core_e26", 4'b1101);
        edges(8);
        chk_out("pulse_user_e34", 4'b1110);

        // 10-cycle high pulse must not release and counts one glitch
        xres_n = 1'b0;
        edges(4);
        chk_out("glitch_hold", 4'b0001);
        xres_n = 1'b1;
        edges(10);
        chk_out("glitch_10hi", 4'b0001);
        xres_n = 1'b0;
        edges(1);
        xres_n = 1'b1;
        edges(18);
        chk_out("glitch_e17", 4'b0001);
`ifdef XRES_GLITCH_CNT_EN
        check("glitch_cnt_1", glitch_cnt, 8'd1);
`endif
        edges(1);
        chk_out("glitch_hk_e18", 4'b1001);

        // Drop while in REL_CORE: user must never rise
        edges(10);
        chk_out("relcore_state", 4'b1101);
        user_seen = 1'b0;
        xres_n = 1'b0;
        edges(2);
        chk_out("relcore_f1", 4'b1101);
        edges(1);
        chk_out("relcore_low", 4'b0001);
        edges(20);
        check("relcore_user_never", {7'd0, user_seen}, 8'd0);

        // resetb asserted mid-DEBOUNCE restarts the count
        xres_n = 1'b1;
        edges(9);
        #2 resetb = 1'b0;
        #1 chk_out("deb_reset_async", 4'b0001);
`ifdef XRES_GLITCH_CNT_EN
        check("deb_reset_glitch_clr", glitch_cnt, 8'd0);
`endif
        edges(3);
        resetb = 1'b1;
        edges(18);
        chk_out("restart_e17", 4'b0001);
        edges(1);
        chk_out("restart_hk_e18", 4'b1001);
        edges(16);
        chk_out("restart_user_e34", 4'b1110);

        // Asynchronous reset in RUN, between clock edges
        #2 resetb = 1'b0;
        #1 chk_out("run_reset_async", 4'b0001);
        edges(2);
        resetb = 1'b1;

        // 300 short glitches
        for (int i = 0; i < 300; i++) begin
            xres_n = 1'b1;
            edges(1);
            xres_n = 1'b0;
            edges(1);
        end
        edges(3);
        chk_out("glitch300_outputs", 4'b0001);
`ifdef XRES_GLITCH_CNT_EN
        check("glitch300_sat", glitch_cnt, 8'd255);
`endif

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xres_reset_sequencer.md
XRES_RESET_SEQUENCER -- requirements
Module: xres_reset_sequencer

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2 (min 2), giving the synchronizer depth for the pad reset input.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 16 (range 1..255), giving the consecutive-high cycles required before release.
REQ-003 The module SHALL have parameter SEQ_DELAY, default 8 (range 1..255), giving the cycles between successive reset-domain releases.
REQ-004 Port clock SHALL be: input, 1 bit, free-running core clock.
REQ-005 Port resetb SHALL be: input, 1 bit, power-on reset, asynchronous, active-low.
REQ-006 Port xres_n SHALL be: input, 1 bit, pad external reset level from the XRES pad, asynchronous to clock, active-low.
REQ-007 Port hk_resetb SHALL be: output, 1 bit, housekeeping reset, active-low.
REQ-008 Port core_resetb SHALL be: output, 1 bit, management core reset, active-low.
REQ-009 Port user_resetb SHALL be: output, 1 bit, user project reset, active-low.
REQ-010 Port seq_busy SHALL be: output, 1 bit, high while any reset domain is still held.
REQ-011 Port glitch_cnt SHALL be: output, 8 bits, count of rejected release pulses; it exists only when the Configuration macro is defined.

Function
REQ-012 xres_n SHALL pass through a SYNC_STAGES-deep flop chain; all logic uses only the synchronized value xs.
REQ-013 The FSM SHALL have states HOLD, DEBOUNCE, REL_HK, REL_CORE and RUN.
- HOLD: all three resets low; go to DEBOUNCE when xs=1.
- DEBOUNCE: an 8-bit counter increments each cycle xs=1; go to REL_HK after DEBOUNCE_CYCLES consecutive xs=1 cycles.
- REL_HK: hk_resetb=1; go to REL_CORE after SEQ_DELAY cycles.
- REL_CORE: core_resetb=1; go to RUN after SEQ_DELAY cycles.
- RUN: user_resetb=1; seq_busy=0.
REQ-014 In any state, xs=0 SHALL force the next state to HOLD, drive all resets low on that same edge, and clear the counter (assertion priority over release).
REQ-015 A drop of xs to 0 while in DEBOUNCE SHALL be a glitch: return to HOLD and restart the count from 0.
REQ-016 Release latency: with xres_n stable high, hk_resetb SHALL rise exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first clock edge that samples xres_n=1. core_resetb SHALL rise SEQ_DELAY clocks after hk_resetb, and user_resetb SEQ_DELAY clocks after core_resetb.
REQ-017 Assertion latency: after xres_n falls, all resets SHALL be low no later than SYNC_STAGES+1 clock edges later.
REQ-018 The release order SHALL always be hk, then core, then user; no output shall ever be high while an earlier-ordered output is low.
REQ-019 seq_busy SHALL be 1 in every state except RUN.
REQ-020 Resets SHALL deassert only from registered outputs (glitch-free); combinational paths to outputs are prohibited.

Reset
REQ-021 With resetb=0, the module SHALL, asynchronously: state=HOLD; synchronizer flops=0; counters=0; hk_resetb=core_resetb=user_resetb=0; seq_busy=1; glitch_cnt=0.
REQ-022 Release of resetb SHALL follow REQ-016 timing with no extra cycles.

Configuration
REQ-023 Macro XRES_GLITCH_CNT_EN defined: glitch_cnt SHALL increment by 1 on each REQ-015 glitch, saturate at 255, and clear only via resetb.
REQ-024 Macro XRES_GLITCH_CNT_EN undefined: the glitch_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults 2/16/8)
REQ-025 resetb low then high, xres_n=1 throughout -> hk_resetb rises at clock 18, core_resetb at 26, user_resetb at 34; seq_busy falls with user_resetb.
REQ-026 In RUN, xres_n low for 1 cycle -> all resets low within 3 edges; once xres_n is high again, the full sequence repeats at 18/26/34.
REQ-027 xres_n high for 10 cycles, low, then high -> no release during the 10-cycle pulse; glitch_cnt=1 (macro on); release 18 clocks after the final rise.
REQ-028 xres_n falls while in REL_CORE -> core_resetb and hk_resetb both low within 3 edges; user_resetb never rises.
REQ-029 300 short glitches (macro on) -> glitch_cnt saturates at 255.
REQ-030 resetb asserted mid-DEBOUNCE -> outputs low immediately without waiting for a clock edge; the counter restarts from 0 after resetb releases.
